// File: rtl/sha_msg_sched.sv
// sha_msg_sched: SHA-256 message schedule and round-constant feeder.
// Accepts one 512-bit padded block, then streams (W_t, K_t, t) for
// t = 0..ROUNDS-1 over a valid/ready interface using a 16-word sliding window.
// Optional build macro: SHA_SCHED_BSWAP_EN byte-reverses each 32-bit input
// word on load (little-endian header layout). The default build loads words
// big-endian, as-is.
module sha_msg_sched #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_o,
    output logic [31:0]  k_o,
    output logic [5:0]   t_o,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state;
    logic [5:0]  t;
    logic [31:0] win [16];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] load_word(input logic [31:0] x);
`ifdef SHA_SCHED_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    // FSM, round counter and sliding window; window advances only on a transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            for (int unsigned i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int unsigned i = 0; i < 16; i++)
                            win[i] <= load_word(blk_data[511 - 32*i -: 32]);
                        t     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
                        win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
                        if (t == T_LAST) begin
                            t     <= '0;
                            state <= IDLE;
                        end else begin
                            t <= t + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from registered state; blk_ready is masked while reset is held
    always_comb begin
        w_valid   = (state == RUN);
        busy      = (state == RUN);
        blk_ready = (state == IDLE) && !reset;
        w_o       = win[0];
        t_o       = t;
        k_o       = K_ROM[t];
        w_last    = (state == RUN) && (t == T_LAST);
    end

endmodule
